signtruncate: RTL and testbench

- Per-lane saturating narrowing block; the inverse of the signextend path.
- Takes DEPTH packed two's-complement lanes of DATA_WIDTH_IN bits and produces DEPTH packed lanes of DATA_WIDTH_OUT bits (DATA_WIDTH_OUT < DATA_WIDTH_IN).
- Values outside the output range clamp to the output max/min, with per-lane flags and an event counter.
- Result passes through a DELAY-stage stallable pipeline; sits on the datapath return leg, after wide arithmetic, ahead of narrow storage.

---
 rtl/signtruncate.sv | 110 +++++++++++
 tb/tb_signtruncate.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/signtruncate.sv
// signtruncate: per-lane saturating narrowing of packed signed lanes,
// followed by a DELAY-stage stallable pipeline plus saturation statistics.
module signtruncate #(
  parameter int DATA_WIDTH_IN  = 8,
  parameter int DEPTH          = 2,
  parameter int DATA_WIDTH_OUT = 4,
  parameter int DELAY          = 1,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_n,
  input  logic                              validIn,
  input  logic [DATA_WIDTH_IN*DEPTH-1:0]    dataIn,
  input  logic                              clrCount,
  output logic [DATA_WIDTH_OUT*DEPTH-1:0]   dataOut,
  output logic                              validOut,
  output logic [DEPTH-1:0]                  satOut,
  output logic                              satSticky,
  output logic [CNT_WIDTH-1:0]              satCount
);

  localparam int WO   = DATA_WIDTH_OUT * DEPTH;
  localparam int TOPW = DATA_WIDTH_IN - DATA_WIDTH_OUT + 1;

  localparam logic [DATA_WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
  localparam logic [DATA_WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}};

  logic [WO-1:0]                w_narrow;
  logic [DEPTH-1:0]             w_sat;
  logic                         w_last_valid;
  logic [DEPTH-1:0]             w_last_sat;

  logic [DELAY-1:0]             r_valid;
  logic [DELAY-1:0][WO-1:0]     r_data;
  logic [DELAY-1:0][DEPTH-1:0]  r_sat;
  logic                         r_sticky;
  logic [CNT_WIDTH-1:0]         r_count;

  // Narrow each lane: a value fits when all bits from the output sign bit
  // upward agree; otherwise clamp toward the side given by the input sign.
  always_comb begin
    logic [DATA_WIDTH_IN-1:0] v_lane;
    logic [TOPW-1:0]          v_top;
    w_narrow = '0;
    w_sat    = '0;
    v_lane   = '0;
    v_top    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_lane = dataIn[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];
      v_top  = v_lane[DATA_WIDTH_IN-1:DATA_WIDTH_OUT-1];
      if ((&v_top) || (~|v_top)) begin
        w_narrow[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = v_lane[DATA_WIDTH_OUT-1:0];
      end else begin
        w_sat[i] = 1'b1;
        w_narrow[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = v_lane[DATA_WIDTH_IN-1] ? OUT_MIN : OUT_MAX;
      end
    end
  end

  // Pipeline stages: all advance together on en_n=0, all hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_sat   <= '0;
    end else if (!en_n) begin
      r_valid[0] <= validIn;
      r_data[0]  <= w_narrow;
      r_sat[0]   <= w_sat;
      for (int unsigned k = 1; k < DELAY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
        r_sat[k]   <= r_sat[k-1];
      end
    end
  end

  // The beat about to enter the last stage drives the statistics, so the
  // counter moves on the same edge the beat becomes visible at the output.
  generate
    if (DELAY == 1) begin : g_last_from_input
      assign w_last_valid = validIn;
      assign w_last_sat   = w_sat;
    end else begin : g_last_from_stage
      assign w_last_valid = r_valid[DELAY-2];
      assign w_last_sat   = r_sat[DELAY-2];
    end
  endgenerate

  // Saturation statistics; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clrCount) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (!en_n && w_last_valid && (|w_last_sat)) begin
      r_sticky <= 1'b1;
      if (r_count != '1) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign dataOut   = r_data[DELAY-1];
  assign validOut  = r_valid[DELAY-1];
  assign satOut    = r_sat[DELAY-1];
  assign satSticky = r_sticky;
  assign satCount  = r_count;

endmodule

// File: tb/tb_signtruncate.sv
// Directed bench for signtruncate: three instances cover default parameters,
// a 2-bit counter and a 3-stage pipeline.
module tb_signtruncate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults (DELAY=1, CNT_WIDTH=8)
  logic       rstA, enA, vA, clrA;
  logic [15:0] dA;
  logic [7:0]  doA;
  logic        voA, stA;
  logic [1:0]  saA;
  logic [7:0]  cA;

  // Instance B: CNT_WIDTH=2
  logic       rstB, enB, vB, clrB;
  logic [15:0] dB;
  logic [7:0]  doB;
  logic        voB, stB;
  logic [1:0]  saB;
  logic [1:0]  cB;

  // Instance C: DELAY=3
  logic       rstC, enC, vC, clrC;
  logic [15:0] dC;
  logic [7:0]  doC;
  logic        voC, stC;
  logic [1:0]  saC;
  logic [7:0]  cC;

  signtruncate u_a (
    .clk(clk), .rst(rstA), .en_n(enA), .validIn(vA), .dataIn(dA), .clrCount(clrA),
    .dataOut(doA), .validOut(voA), .satOut(saA), .satSticky(stA), .satCount(cA)
  );

  signtruncate #(.CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rstB), .en_n(enB), .validIn(vB), .dataIn(dB), .clrCount(clrB),
    .dataOut(doB), .validOut(voB), .satOut(saB), .satSticky(stB), .satCount(cB)
  );

  signtruncate #(.DELAY(3)) u_c (
    .clk(clk), .rst(rstC), .en_n(enC), .validIn(vC), .dataIn(dC), .clrCount(clrC),
    .dataOut(doC), .validOut(voC), .satOut(saC), .satSticky(stC), .satCount(cC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstA = 1'b1; enA = 1'b1; vA = 1'b0; clrA = 1'b0; dA = '0;
    rstB = 1'b1; enB = 1'b1; vB = 1'b0; clrB = 1'b0; dB = '0;
    rstC = 1'b1; enC = 1'b1; vC = 1'b0; clrC = 1'b0; dC = '0;
    tick();
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

    chk("A_rst_data",  32'(doA), 32'h00);
    chk("A_rst_valid", 32'(voA), 32'h0);
    chk("A_rst_sat",   32'(saA), 32'h0);
    chk("A_rst_cnt",   32'(cA),  32'h0);
    chk("A_rst_stk",   32'(stA), 32'h0);
    chk("C_rst_valid", 32'(voC), 32'h0);

    // ---- Instance A: narrowing ----
    enA = 1'b0; vA = 1'b1; dA = 16'h05FB; tick();
    chk("A_inrange_data",  32'(doA), 32'h5B);
    chk("A_inrange_sat",   32'(saA), 32'h0);
    chk("A_inrange_valid", 32'(voA), 32'h1);
    chk("A_inrange_cnt",   32'(cA),  32'h0);
    chk("A_inrange_stk",   32'(stA), 32'h0);

    dA = 16'h0708; tick();
    chk("A_max_data", 32'(doA), 32'h77);
    chk("A_max_sat",  32'(saA), 32'h1);
    chk("A_max_cnt",  32'(cA),  32'h1);
    chk("A_max_stk",  32'(stA), 32'h1);

    dA = 16'hF8F7; tick();
    chk("A_min_data", 32'(doA), 32'h88);
    chk("A_min_sat",  32'(saA), 32'h1);
    chk("A_min_cnt",  32'(cA),  32'h2);

    dA = 16'h7F80; tick();
    chk("A_both_data", 32'(doA), 32'h78);
    chk("A_both_sat",  32'(saA), 32'h3);
    chk("A_both_cnt",  32'(cA),  32'h3);
    chk("A_both_stk",  32'(stA), 32'h1);

    // Invalid beats do not count
    vA = 1'b0; dA = 16'h7F7F;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("A_inv_valid", 32'(voA), 32'h0);
      chk("A_inv_cnt",   32'(cA),  32'h3);
    end
    enA = 1'b1;

    // ---- Instance B: 2-bit counter saturation ----
    enB = 1'b0; vB = 1'b1; dB = 16'h7F80;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("B_sat_cnt",   32'(cB),  (i < 3) ? 32'(i) : 32'h3);
      chk("B_sat_valid", 32'(voB), 32'h1);
    end
    chk("B_sat_stk", 32'(stB), 32'h1);
    clrB = 1'b1; tick();
    chk("B_clr_cnt",  32'(cB),  32'h0);
    chk("B_clr_stk",  32'(stB), 32'h0);
    chk("B_clr_data", 32'(doB), 32'h78);
    clrB = 1'b0; tick();
    chk("B_recount", 32'(cB), 32'h1);
    // Clear while stalled
    enB = 1'b1; clrB = 1'b1; tick();
    chk("B_clr_stall_cnt", 32'(cB),  32'h0);
    chk("B_clr_stall_stk", 32'(stB), 32'h0);
    chk("B_clr_stall_vo",  32'(voB), 32'h1);
    clrB = 1'b0;

    // ---- Instance C: stall with DELAY=3 ----
    enC = 1'b0; vC = 1'b1; dC = 16'h0102; tick();
    chk("C_cap_valid", 32'(voC), 32'h0);
    enC = 1'b1; dC = 16'h7F7F;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("C_stall_valid", 32'(voC), 32'h0);
      chk("C_stall_data",  32'(doC), 32'h00);
    end
    enC = 1'b0; vC = 1'b0; dC = 16'h0000; tick();
    chk("C_e2_valid", 32'(voC), 32'h0);
    tick();
    chk("C_e3_valid", 32'(voC), 32'h1);
    chk("C_e3_data",  32'(doC), 32'h12);
    chk("C_e3_sat",   32'(saC), 32'h0);

    // ---- Instance C: reset mid-operation ----
    vC = 1'b1; dC = 16'h7F80;
    tick();
    chk("C_s4_valid", 32'(voC), 32'h0);
    tick();
    chk("C_s5_valid", 32'(voC), 32'h0);
    tick();
    chk("C_s6_valid", 32'(voC), 32'h1);
    chk("C_s6_data",  32'(doC), 32'h78);
    chk("C_s6_cnt",   32'(cC),  32'h1);
    chk("C_s6_stk",   32'(stC), 32'h1);
    vC = 1'b0; dC = 16'h0000; rstC = 1'b1; tick();
    rstC = 1'b0;
    chk("C_rst_data2",  32'(doC), 32'h00);
    chk("C_rst_valid2", 32'(voC), 32'h0);
    chk("C_rst_sat2",   32'(saC), 32'h0);
    chk("C_rst_cnt2",   32'(cC),  32'h0);
    chk("C_rst_stk2",   32'(stC), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("C_post_rst_valid", 32'(voC), 32'h0);
      chk("C_post_rst_cnt",   32'(cC),  32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
